// File: rtl/cache_array_if.sv
// Request/response bus for cache_array: requester drives the master side, the cache the slave side.
interface cache_array_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAT_W = 16
);
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_val;
  logic              read;
  logic              write;
  logic              force_write;
  logic              invalidate;
  logic              resp_valid;
  logic              hit;
  logic [DATA_W-1:0] out_val;
  logic [STAT_W-1:0] hit_count;
  logic [STAT_W-1:0] miss_count;

  modport master (
    output in_addr, in_val, read, write, force_write, invalidate,
    input  resp_valid, hit, out_val, hit_count, miss_count
  );

  modport slave (
    input  in_addr, in_val, read, write, force_write, invalidate,
    output resp_valid, hit, out_val, hit_count, miss_count
  );
endinterface

// File: rtl/cache_array.sv
// Fully associative cache with forced allocation and round-robin replacement.
// Hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
module cache_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 4,
  parameter int unsigned STAT_W = 16
) (
  input logic            clock,
  input logic            reset_n,
  cache_array_if.slave   bus
);
  localparam int unsigned IdxW = $clog2(LINES);

  logic [LINES-1:0]  valid_q;
  logic [ADDR_W-1:0] tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [IdxW-1:0]   vptr_q;
  logic              resp_valid_q;
  logic              hit_q;
  logic [DATA_W-1:0] out_val_q;

  logic            match_any;
  logic [IdxW-1:0] match_idx;
  logic            free_any;
  logic [IdxW-1:0] free_idx;
  logic            req_accept;
  logic            do_read;
  logic            do_write;
  logic            do_alloc;
  logic [IdxW-1:0] alloc_idx;

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == bus.in_addr)) begin
        match_any = 1'b1;
        match_idx = IdxW'(i);
      end
    end
    // Scan downwards so the lowest-indexed invalid line wins.
    free_any = 1'b0;
    free_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  assign req_accept = !bus.invalidate && (bus.read || bus.write);
  assign do_read    = !bus.invalidate && bus.read;
  assign do_write   = !bus.invalidate && !bus.read && bus.write;
  assign do_alloc   = do_write && !match_any && bus.force_write;
  assign alloc_idx  = free_any ? free_idx : vptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      vptr_q       <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      out_val_q    <= '0;
    end else if (bus.invalidate) begin
      valid_q      <= '0;
      vptr_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= req_accept;
      if (req_accept) hit_q <= match_any;
      if (do_read && match_any) out_val_q <= data_q[match_idx];
      if (do_alloc) begin
        valid_q[alloc_idx] <= 1'b1;
        if (!free_any) vptr_q <= vptr_q + 1'b1;
      end
    end
  end

  // Tag and data storage carries no reset; valid bits guard it.
  always_ff @(posedge clock) begin
    if (do_write && match_any) data_q[match_idx] <= bus.in_val;
    if (do_alloc) begin
      tag_q[alloc_idx]  <= bus.in_addr;
      data_q[alloc_idx] <= bus.in_val;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.hit        = hit_q;
  assign bus.out_val    = out_val_q;

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (req_accept) begin
      if (match_any) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = {STAT_W{1'b0}};
  assign bus.miss_count = {STAT_W{1'b0}};
`endif
endmodule

// File: tb/tb_cache_array.sv
// Self-checking bench for cache_array: directed steps then random traffic against a line-table model.
module tb_cache_array;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINES  = 4;
  localparam int unsigned STAT_W = 4;
  localparam int          STAT_MAX = (1 << STAT_W) - 1;

  logic clock;
  logic reset_n;

  cache_array_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAT_W(STAT_W)) bus ();

  cache_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LINES (LINES),
    .STAT_W(STAT_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: a table of lines plus expected registered outputs.
  bit                m_valid [LINES];
  logic [ADDR_W-1:0] m_tag   [LINES];
  logic [DATA_W-1:0] m_data  [LINES];
  int                m_vptr;
  bit                e_rv;
  bit                e_hit;
  logic [DATA_W-1:0] e_out;
  int                e_hc;
  int                e_mc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'(e_rv));
    chk({tag, ".hit"}, 64'(bus.hit), 64'(e_hit));
    chk({tag, ".out_val"}, 64'(bus.out_val), 64'(e_out));
`ifdef CACHE_STATS_EN
    chk({tag, ".hit_count"}, 64'(bus.hit_count), 64'(e_hc));
    chk({tag, ".miss_count"}, 64'(bus.miss_count), 64'(e_mc));
`else
    chk({tag, ".hit_count"}, 64'(bus.hit_count), 64'd0);
    chk({tag, ".miss_count"}, 64'(bus.miss_count), 64'd0);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_vptr = 0;
    e_rv = 1'b0;
    e_hit = 1'b0;
    e_out = '0;
    e_hc = 0;
    e_mc = 0;
  endtask

  task automatic model_step(input bit rd, input bit wr, input bit fw, input bit inv,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
    int idx;
    int victim;
    idx = -1;
    if (inv) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_vptr = 0;
      e_rv = 1'b0;
      return;
    end
    if (!rd && !wr) begin
      e_rv = 1'b0;
      return;
    end
    for (int i = 0; i < LINES; i++) if (m_valid[i] && m_tag[i] == addr) idx = i;
    e_rv = 1'b1;
    e_hit = (idx >= 0);
    if (idx >= 0) e_hc = (e_hc < STAT_MAX) ? e_hc + 1 : e_hc;
    else          e_mc = (e_mc < STAT_MAX) ? e_mc + 1 : e_mc;
    if (rd) begin
      if (idx >= 0) e_out = m_data[idx];
    end else if (idx >= 0) begin
      m_data[idx] = val;
    end else if (fw) begin
      victim = -1;
      for (int i = LINES - 1; i >= 0; i--) if (!m_valid[i]) victim = i;
      if (victim < 0) begin
        victim = m_vptr;
        m_vptr = (m_vptr + 1) % LINES;
      end
      m_valid[victim] = 1'b1;
      m_tag[victim] = addr;
      m_data[victim] = val;
    end
  endtask

  // One request cycle: drive, clock, advance model, check 1 time unit after the edge.
  task automatic cyc(input string tag, input bit rd, input bit wr, input bit fw, input bit inv,
                     input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
    bus.read = rd;
    bus.write = wr;
    bus.force_write = fw;
    bus.invalidate = inv;
    bus.in_addr = addr;
    bus.in_val = val;
    @(posedge clock);
    model_step(rd, wr, fw, inv, addr, val);
    #1;
    check_all(tag);
  endtask

  task automatic rd_(input string tag, input logic [ADDR_W-1:0] a);
    cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, a, '0);
  endtask

  task automatic fwr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    cyc(tag, 1'b0, 1'b1, 1'b1, 1'b0, a, v);
  endtask

  initial begin
    bit rd, wr, fw, inv;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.force_write = 1'b0;
    bus.invalidate = 1'b0;
    bus.in_addr = '0;
    bus.in_val = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    rd_("rd_after_reset", 8'h10);
    fwr("fw_10", 8'h10, 32'hDEADBEEF);
    rd_("rd_10_a", 8'h10);
    cyc("wr_10_plain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h1);
    rd_("rd_10_b", 8'h10);
    cyc("wr_22_nof", 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 32'h5);
    rd_("rd_22", 8'h22);
    cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
    cyc("rd_wr_both", 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 32'h77);
    rd_("rd_33_dropped", 8'h33);

    // Round-robin fill after a clean invalidate.
    cyc("inv0", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
    for (int a = 1; a <= 6; a++) fwr("rr_fill", 8'(a), 32'h100 + 32'(a));
    for (int a = 1; a <= 6; a++) rd_("rr_read", 8'(a));
    for (int a = 7; a <= 11; a++) fwr("rr_more", 8'(a), 32'h200 + 32'(a));
    for (int a = 3; a <= 11; a++) rd_("rr_read2", 8'(a));

    cyc("inv_with_read", 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, '0);
    for (int a = 1; a <= 11; a += 2) rd_("rd_after_inv", 8'(a));
    fwr("fw_after_inv", 8'h30, 32'hCAFE0000);
    for (int a = 1; a <= 4; a++) fwr("refill", 8'h30 + 8'(a), 32'hCAFE0000 + 32'(a));
    rd_("rd_30_evicted", 8'h30);
    rd_("rd_31", 8'h31);

    // Drop reset while a read is pending.
    bus.read = 1'b1;
    bus.in_addr = 8'h31;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("reset_mid");
    bus.read = 1'b0;
    @(posedge clock);
    #1;
    check_all("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;

    fwr("sat_fill", 8'h40, 32'h12345678);
    for (int k = 0; k < 20; k++) rd_("sat_rd", 8'h40);
`ifdef CACHE_STATS_EN
    chk("hit_saturated", 64'(bus.hit_count), 64'd15);
`else
    chk("hit_count_off", 64'(bus.hit_count), 64'd0);
`endif

    for (int k = 0; k < 400; k++) begin
      inv = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 1) == 0);
      fw  = ($urandom_range(0, 1) == 0);
      cyc("random", rd, wr, fw, inv, 8'($urandom_range(0, 7)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
